// File: rtl/led_shift_pkg.sv
// led_shift_pkg: encodings, default dividers and FSM type shared by the LED tick generator and shifter
package led_shift_pkg;
  localparam logic [1:0] SEL_100MS = 2'd0;
  localparam logic [1:0] SEL_10MS  = 2'd1;
  localparam logic [1:0] SEL_1MS   = 2'd2;
  localparam logic [1:0] SEL_100US = 2'd3;
  localparam int DIV0_DEF    = 5000000;
  localparam int DIV1_DEF    = 500000;
  localparam int DIV2_DEF    = 50000;
  localparam int DIV3_DEF    = 5000;
  localparam int DEB_CYC_DEF = 1000;
  localparam logic [1:0] MODE_SHIFT_L = 2'd0;
  localparam logic [1:0] MODE_SHIFT_R = 2'd1;
  localparam logic [1:0] MODE_BOUNCE  = 2'd2;
  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_RESTART} tick_state_t;
  function automatic int simfast_div(input int d);
    return (d / 1000 < 2) ? 2 : d / 1000;
  endfunction
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchronizer plus stable-run counter; upd pulses combinationally on the accepting edge
module sw_debounce #(
  parameter int WIDTH   = 2,
  parameter int DEB_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] out,
  output logic             upd
);
  localparam int CW = $clog2(DEB_CYC);
  logic [WIDTH-1:0] s1, s2, s2_q;
  logic [CW-1:0] cnt;
  logic clr;
  assign clr = (s2 != s2_q) || (s2 == out);
  assign upd = !clr && (cnt == CW'(DEB_CYC - 2));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1   <= '0;
      s2   <= '0;
      s2_q <= '0;
      cnt  <= '0;
      out  <= '0;
    end else begin
      s1   <= sw;
      s2   <= s1;
      s2_q <= s2;
      cnt  <= clr ? '0 : cnt + 1'b1;
      if (upd) out <= s2;
    end
endmodule

// File: rtl/led_step_tick_gen.sv
// led_step_tick_gen: debounced sel/mode plus one-cycle step and restart pulses for the LED shifter.
// Define LED_TICK_SIMFAST_EN to divide every DIVn by 1000 (min 2) and force a 4-cycle debounce.
module led_step_tick_gen
  import led_shift_pkg::*;
#(
  parameter int DIV0    = DIV0_DEF,
  parameter int DIV1    = DIV1_DEF,
  parameter int DIV2    = DIV2_DEF,
  parameter int DIV3    = DIV3_DEF,
  parameter int DEB_CYC = DEB_CYC_DEF,
  parameter int CNT_W   = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel_sw,
  input  logic [1:0] mode_sw,
  input  logic       hold,
  output logic [1:0] sel,
  output logic [1:0] mode,
  output logic       step,
  output logic       restart
);
`ifdef LED_TICK_SIMFAST_EN
  localparam int D0  = simfast_div(DIV0);
  localparam int D1  = simfast_div(DIV1);
  localparam int D2  = simfast_div(DIV2);
  localparam int D3  = simfast_div(DIV3);
  localparam int DEB = 4;
`else
  localparam int D0  = DIV0;
  localparam int D1  = DIV1;
  localparam int D2  = DIV2;
  localparam int D3  = DIV3;
  localparam int DEB = DEB_CYC;
`endif
  tick_state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, lim;
  logic sel_upd, mode_upd, chg, run, step_d, restart_d;
  sw_debounce #(.WIDTH(2), .DEB_CYC(DEB)) u_sel_deb (
    .clk(clk), .reset(reset), .sw(sel_sw), .out(sel), .upd(sel_upd)
  );
  sw_debounce #(.WIDTH(2), .DEB_CYC(DEB)) u_mode_deb (
    .clk(clk), .reset(reset), .sw(mode_sw), .out(mode), .upd(mode_upd)
  );
  assign lim = (sel == SEL_100MS) ? CNT_W'(D0 - 1) :
               (sel == SEL_10MS)  ? CNT_W'(D1 - 1) :
               (sel == SEL_1MS)   ? CNT_W'(D2 - 1) : CNT_W'(D3 - 1);
  // a debounced change pre-empts a coincident terminal count, so that step is dropped
  always_comb begin
    chg       = sel_upd | mode_upd;
    restart_d = (state == ST_INIT) || (state == ST_RUN && chg);
    run       = (state == ST_RUN) && !chg && !hold;
    step_d    = run && (cnt == lim);
    cnt_d     = (state != ST_RUN || chg) ? '0 : !run ? cnt : step_d ? '0 : cnt + 1'b1;
    state_d   = restart_d ? ST_RESTART : ST_RUN;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= ST_INIT;
      cnt     <= '0;
      step    <= 1'b0;
      restart <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      step    <= step_d;
      restart <= restart_d;
    end
endmodule

// File: tb/tb_led_step_tick_gen.sv
// tb_led_step_tick_gen: cycle-by-cycle model comparison plus hand-computed event timings
module tb_led_step_tick_gen;
  localparam int DEB = 4;
  localparam int DIVS [4] = '{32, 16, 8, 4};
  logic clk = 1'b0, reset = 1'b1, hold = 1'b0;
  logic [1:0] sel_sw = 2'd0, mode_sw = 2'd0;
  logic [1:0] sel, mode;
  logic step, restart;
  int tests = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  led_step_tick_gen #(
    .DIV0(32), .DIV1(16), .DIV2(8), .DIV3(4), .DEB_CYC(DEB), .CNT_W(23)
  ) dut (
    .clk(clk), .reset(reset), .sel_sw(sel_sw), .mode_sw(mode_sw), .hold(hold),
    .sel(sel), .mode(mode), .step(step), .restart(restart)
  );
  always @(posedge clk or negedge reset) cyc <= !reset ? 0 : cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(got), $signed(exp));
    end
  endtask
  // model: a switch value is accepted once it was sampled DEB times in a row (2-cycle sync lag);
  // steps fall on every DIV-th unheld running cycle counted from the end of a restart
  logic [1:0] hs [0:DEB];
  logic [1:0] hm [0:DEB];
  logic [1:0] m_sel = 2'd0, m_mode = 2'd0;
  logic m_step = 1'b0, m_rst = 1'b0, m_init = 1'b1;
  int acc = 0;
  logic st_s, st_m, chg_s, chg_m, nr, ce, nstep;
  always_comb begin
    st_s = 1'b1;
    st_m = 1'b1;
    for (int i = 2; i <= DEB; i++) begin
      if (hs[i] !== hs[1]) st_s = 1'b0;
      if (hm[i] !== hm[1]) st_m = 1'b0;
    end
    chg_s = st_s && (hs[1] !== m_sel);
    chg_m = st_m && (hm[1] !== m_mode);
    nr    = m_init || (!m_rst && (chg_s || chg_m));
    ce    = !m_init && !m_rst && !chg_s && !chg_m && !hold;
    nstep = ce && (((acc + 1) % DIVS[m_sel]) == 0);
  end
  always @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i <= DEB; i++) begin
        hs[i] <= 2'd0;
        hm[i] <= 2'd0;
      end
      m_sel <= 2'd0;
      m_mode <= 2'd0;
      m_step <= 1'b0;
      m_rst <= 1'b0;
      m_init <= 1'b1;
      acc <= 0;
    end else begin
      hs[0] <= sel_sw;
      hm[0] <= mode_sw;
      for (int i = 1; i <= DEB; i++) begin
        hs[i] <= hs[i-1];
        hm[i] <= hm[i-1];
      end
      if (chg_s) m_sel <= hs[1];
      if (chg_m) m_mode <= hm[1];
      m_rst <= nr;
      m_step <= nstep;
      m_init <= 1'b0;
      acc <= (m_rst || nr) ? 0 : ce ? acc + 1 : acc;
    end
  always @(negedge clk) begin
    chk("sel", 32'(sel), 32'(m_sel));
    chk("mode", 32'(mode), 32'(m_mode));
    chk("step", 32'(step), 32'(m_step));
    chk("restart", 32'(restart), 32'(m_rst));
  end
  // returns the cycle index of the first pulse (w=1 restart, w=0 step), or -1 after maxc cycles
  task automatic wait_sig(input bit w, input int maxc, output int c);
    bit done = 1'b0;
    c = -1;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk);
      if ((w ? restart : step) === 1'b1) begin
        c = cyc;
        done = 1'b1;
      end
    end
  endtask
  initial begin
    int c;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {28'd0, sel, mode, step, restart}, 32'd0);
    reset = 1'b1;
    wait_sig(1'b1, 5, c);  chk("init_restart_cyc", c, 1);
    wait_sig(1'b0, 40, c); chk("div0_first_step", c, 34);
    wait_sig(1'b0, 40, c); chk("div0_second_step", c, 66);
    sel_sw = 2'd3;
    wait_sig(1'b1, 10, c); chk("sel3_restart_cyc", c, 72);
    chk("sel3_value", 32'(sel), 3);
    wait_sig(1'b0, 10, c); chk("div3_first_step", c, 77);
    wait_sig(1'b0, 10, c); chk("div3_second_step", c, 81);
    mode_sw = 2'd2;
    repeat (3) @(negedge clk);
    mode_sw = 2'd0;
    wait_sig(1'b1, 12, c); chk("glitch_no_restart", c, -1);
    chk("glitch_mode", 32'(mode), 0);
    mode_sw = 2'd2;
    wait_sig(1'b1, 10, c); chk("mode2_restart_cyc", c, 102);
    chk("mode2_value", 32'(mode), 2);
    sel_sw = 2'd2;
    wait_sig(1'b1, 10, c); chk("sel2_restart_cyc", c, 108);
    repeat (4) @(negedge clk);
    hold = 1'b1;
    wait_sig(1'b0, 20, c); chk("hold_no_step", c, -1);
    hold = 1'b0;
    wait_sig(1'b0, 10, c); chk("hold_resume_step", c, 137);
    repeat (2) @(negedge clk);
    sel_sw = 2'd1;
    mode_sw = 2'd1;
    wait_sig(1'b1, 10, c); chk("both_restart_cyc", c, 145);
    chk("both_step_dropped", 32'(step), 0);
    chk("both_values", {28'd0, sel, mode}, 32'b0101);
    wait_sig(1'b1, 10, c); chk("single_restart", c, -1);
    wait_sig(1'b0, 20, c); chk("div1_first_step", c, 162);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("async_reset_outputs", {28'd0, sel, mode, step, restart}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_sig(1'b1, 5, c);  chk("reinit_restart_cyc", c, 1);
    wait_sig(1'b1, 10, c); chk("redebounce_restart_cyc", c, 6);
    chk("redebounce_values", {28'd0, sel, mode}, 32'b0101);
    wait_sig(1'b0, 25, c); chk("redebounce_first_step", c, 23);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
